spi_master_tx: RTL and testbench
================================

# spi_master_tx

Mode-0 SPI master transmitter that shifts the PID controller's stimulus word out to an external DAC or actuator. It is the output-side counterpart of the PV-input SPI master. It is triggered by the one-cycle PID-update strobe and drives the unused `io_out[2]` pin as MOSI. A one-deep pending register absorbs a new start that arrives while a frame is in flight; the latest word wins.

## Interface
- `WIDTH`, default 4: bits per frame; legal range ≥1.
- `DIV`, default 1: clk cycles per SCK half-period; legal range 1..255; constant.
- `clk`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `in_buf`  in  WIDTH: word to transmit; sampled only when a frame is accepted.
- `start`  in  1: one-cycle request to transmit `in_buf`.
- `sck`  out  1: serial clock; idles low (CPOL=0).
- `cs`  out  1: chip select, active-low; idles high.
- `mosi`  out  1: serial data, MSB first; changes on SCK falling edges only.
- `busy`  out  1: high from frame accept to the end of the post-frame gap.
- `done`  out  1: one-cycle pulse when `cs` deasserts at frame end.
- `overrun`  out  1: one-cycle pulse when a pending word is overwritten.

## Operation
- States: IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP. A single down-counter of width ceil(log2(DIV+1)) times each phase.
- IDLE: `cs`=1, `sck`=0, `mosi`=0, `busy`=0.
  - `start`=1 latches `in_buf` into the shift register.
  - On the same edge: `cs`←0, `mosi`←`in_buf[WIDTH-1]`, `busy`←1, go to SETUP.
- SETUP: DIV cycles with `sck`=0, then `sck`←1 and go to SHIFT_HI.
- SHIFT_HI: DIV cycles with `sck`=1, then `sck`←0.
  - Bits remaining: shift left and drive the next bit on `mosi`; go to SHIFT_LO.
  - Last bit: hold `mosi` and go to HOLD.
- SHIFT_LO: DIV cycles with `sck`=0, then `sck`←1 and go to SHIFT_HI.
- HOLD: DIV cycles with `sck`=0, then `cs`←1, `mosi`←0, `done`←1 for one cycle; go to GAP.
- GAP: DIV cycles with `cs`=1. At the end:
  - If a word is pending or `start`=1 this cycle, launch a new frame directly (same actions as the IDLE accept; `busy` stays 1).
  - Otherwise go to IDLE and set `busy`←0.
- Pending register (1 entry, valid flag):
  - `start` while `busy`=1 and not launching: word goes to pending, valid←1.
  - If valid was already 1: the word overwrites pending and `overrun` pulses.
- Launch precedence at GAP end:
  - Pending valid: launch the pending word. A same-cycle `start` word goes into pending (valid stays 1, no overrun).
  - Pending empty: launch the `start` word.
- `in_buf` changes after the accept edge do not affect the frame in flight.
- Reset at any point: `cs`=1, `sck`=0, `mosi`=0, `busy`=0, `done`=0, `overrun`=0, pending cleared, state IDLE. No `done` is issued for an aborted frame.
- All outputs are registered; no combinational path from inputs to outputs.

## Timing
- Let E0 be the accept edge. Frame accepted in IDLE has zero cycles of latency: `cs` is low and `mosi`=MSB in the cycle after E0.
- Rising edges of SCK at E0+(2k+1)·DIV and falling edges at E0+(2k+2)·DIV, for k=0..WIDTH-1.
- Bit WIDTH-1-k is stable on `mosi` for DIV cycles before and after rising edge k.
- `cs` rises at E0+(2·WIDTH+1)·DIV. `done` is high in the cycle following that edge.
- `busy` falls, or the next frame launches, at E0+(2·WIDTH+2)·DIV.
- Minimum `cs`-high gap between back-to-back frames: DIV cycles.
- Frame period: (2·WIDTH+2)·DIV cycles.
- WIDTH=4, DIV=1:
  - SCK rises at E1, E3, E5, E7 and falls at E2, E4, E6, E8.
  - `cs` high again at E9.
  - Next launch possible at E10.

## Test plan
- Single frame, WIDTH=4, DIV=1, `in_buf`=4'hA, `start` at E0 → `mosi` sampled on SCK rises at E1/E3/E5/E7 reads 1,0,1,0; `cs` low over E0..E9; `done` one pulse after E9; `busy` low after E10.
- DIV=3, `in_buf`=4'h5 → each SCK half-period is 3 cycles; `cs` low for 27 cycles; bits 0,1,0,1; `done` at E27.
- Queued frame: start 4'h3 at E0, start 4'hC at E4 → second frame launches at E10 with no intervening IDLE; `busy` continuous; two `done` pulses, 10 cycles apart.
- Overrun: start 4'h1 at E0, 4'h2 at E3, 4'h7 at E5 → `overrun` pulses once after E5; the second frame transmits 4'h7; 4'h2 is never sent.
- Reset at E4 mid-frame → next cycle `cs`=1, `sck`=0, `mosi`=0, `busy`=0, pending empty, no `done`; a start at E6 begins a clean frame.
- `in_buf` changed from 4'hF to 4'h0 at E2 after accepting 4'hF → all four transmitted bits are 1.

Source files
------------

// File: rtl/spi_master_tx_if.sv
// Bus bundle between the PID stimulus path and the mode-0 SPI transmitter.
// master = transmitter side, slave = the logic that feeds it and watches its pins.
interface spi_master_tx_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] in_buf;
    logic             start;
    logic             sck;
    logic             cs;
    logic             mosi;
    logic             busy;
    logic             done;
    logic             overrun;

    modport master (
        input  in_buf, start,
        output sck, cs, mosi, busy, done, overrun
    );

    modport slave (
        output in_buf, start,
        input  sck, cs, mosi, busy, done, overrun
    );
endinterface

// File: rtl/spi_master_tx.sv
// Mode-0 SPI master transmitter: shifts a WIDTH-bit word out MSB first on MOSI.
// A one-deep pending slot holds a start that arrives mid-frame; the newest word wins.
module spi_master_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic              clk,
    input  logic              reset,
    spi_master_tx_if.master   bus
);
    localparam int CW = (DIV < 2) ? 1 : $clog2(DIV + 1);
    localparam int BW = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);
    localparam logic [BW-1:0] BIT_LOAD = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT_HI, SHIFT_LO, HOLD, GAP} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [BW-1:0]    bit_cnt, bit_cnt_n;
    logic [WIDTH-1:0] shreg, shreg_n, shifted;
    logic [WIDTH-1:0] pend, pend_n, launch_word;
    logic             pend_valid, pend_valid_n;
    logic             sck_r, sck_n, cs_r, cs_n, mosi_r, mosi_n;
    logic             busy_r, busy_n, done_r, done_n, overrun_r, overrun_n;
    logic             launch, phase_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= CNT_LOAD;
            bit_cnt    <= '0;
            shreg      <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
            sck_r      <= 1'b0;
            cs_r       <= 1'b1;
            mosi_r     <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            bit_cnt    <= bit_cnt_n;
            shreg      <= shreg_n;
            pend       <= pend_n;
            pend_valid <= pend_valid_n;
            sck_r      <= sck_n;
            cs_r       <= cs_n;
            mosi_r     <= mosi_n;
            busy_r     <= busy_n;
            done_r     <= done_n;
            overrun_r  <= overrun_n;
        end
    end

    // Every phase lasts DIV cycles; the shared counter reloads whenever a phase ends.
    always_comb begin
        state_n      = state;
        bit_cnt_n    = bit_cnt;
        shreg_n      = shreg;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        sck_n        = sck_r;
        cs_n         = cs_r;
        mosi_n       = mosi_r;
        busy_n       = busy_r;
        done_n       = 1'b0;
        overrun_n    = 1'b0;
        launch       = 1'b0;
        launch_word  = bus.in_buf;
        shifted      = shreg << 1;
        phase_end    = (cnt == '0);
        cnt_n        = phase_end ? CNT_LOAD : cnt - 1'b1;

        case (state)
            IDLE: begin
                cnt_n = CNT_LOAD;
                if (bus.start) launch = 1'b1;
            end
            SETUP: if (phase_end) begin
                sck_n   = 1'b1;
                state_n = SHIFT_HI;
            end
            SHIFT_HI: if (phase_end) begin
                sck_n = 1'b0;
                if (bit_cnt != '0) begin
                    shreg_n   = shifted;
                    mosi_n    = shifted[WIDTH-1];
                    bit_cnt_n = bit_cnt - 1'b1;
                    state_n   = SHIFT_LO;
                end else begin
                    state_n = HOLD;
                end
            end
            SHIFT_LO: if (phase_end) begin
                sck_n   = 1'b1;
                state_n = SHIFT_HI;
            end
            HOLD: if (phase_end) begin
                cs_n    = 1'b1;
                mosi_n  = 1'b0;
                done_n  = 1'b1;
                state_n = GAP;
            end
            GAP: if (phase_end) begin
                if (pend_valid || bus.start) begin
                    launch = 1'b1;
                end else begin
                    busy_n  = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // A queued word outranks a same-cycle start, which then takes its place in the slot.
        if (launch) begin
            if (pend_valid) begin
                launch_word = pend;
                if (bus.start) pend_n = bus.in_buf;
                else           pend_valid_n = 1'b0;
            end
            shreg_n   = launch_word;
            mosi_n    = launch_word[WIDTH-1];
            cs_n      = 1'b0;
            busy_n    = 1'b1;
            bit_cnt_n = BIT_LOAD;
            cnt_n     = CNT_LOAD;
            state_n   = SETUP;
        end else if (bus.start && busy_r) begin
            pend_n       = bus.in_buf;
            pend_valid_n = 1'b1;
            overrun_n    = pend_valid;
        end
    end

    assign bus.sck     = sck_r;
    assign bus.cs      = cs_r;
    assign bus.mosi    = mosi_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.overrun = overrun_r;
endmodule

// File: tb/tb_spi_master_tx.sv
// Directed bench for spi_master_tx: DIV=1 and DIV=3 instances, expected pin
// waveforms derived from the frame timing equations relative to the accept edge.
module tb_spi_master_tx;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    spi_master_tx_if #(.WIDTH(4)) bus1 ();
    spi_master_tx_if #(.WIDTH(4)) bus3 ();

    spi_master_tx #(.WIDTH(4), .DIV(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    spi_master_tx #(.WIDTH(4), .DIV(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected {cs, sck, mosi, busy, done} n cycles after the accept edge of word w.
    function automatic logic [4:0] model(input int n, input logic [3:0] w, input int d);
        int   k;
        logic cs_e, sck_e, mosi_e, busy_e, done_e;
        cs_e  = (n >= 9 * d);
        sck_e = 1'b0;
        for (int b = 0; b < 4; b++)
            if (n >= (2 * b + 1) * d && n < (2 * b + 2) * d) sck_e = 1'b1;
        k = n / (2 * d);
        if (k > 3) k = 3;
        mosi_e = cs_e ? 1'b0 : w[3 - k];
        busy_e = (n < 10 * d);
        done_e = (n == 9 * d);
        return {cs_e, sck_e, mosi_e, busy_e, done_e};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        vectors++;
        if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done, bus1.overrun} !== 6'b100000) begin
            miscompares++;
            $display("[TB] FAIL reset_div1 got=%b want=100000",
                     {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done, bus1.overrun});
        end
        vectors++;
        if ({bus3.cs, bus3.sck, bus3.mosi, bus3.busy, bus3.done, bus3.overrun} !== 6'b100000) begin
            miscompares++;
            $display("[TB] FAIL reset_div3 got=%b want=100000",
                     {bus3.cs, bus3.sck, bus3.mosi, bus3.busy, bus3.done, bus3.overrun});
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [4:0] exp;
        bus1.in_buf = 4'hA;
        bus1.start  = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int n = 0; n <= 11; n++) begin
            exp = model(n, 4'hA, 1);
            vectors++;
            if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done} !== exp || bus1.overrun !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL single n=%0d got=%b/%b want=%b/0", n,
                         {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done}, bus1.overrun, exp);
            end
            step();
        end
    endtask

    task automatic test_div3();
        logic [4:0] exp;
        bus3.in_buf = 4'h5;
        bus3.start  = 1'b1;
        step();
        bus3.start = 1'b0;
        for (int n = 0; n <= 31; n++) begin
            exp = model(n, 4'h5, 3);
            vectors++;
            if ({bus3.cs, bus3.sck, bus3.mosi, bus3.busy, bus3.done} !== exp || bus3.overrun !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL div3 n=%0d got=%b/%b want=%b/0", n,
                         {bus3.cs, bus3.sck, bus3.mosi, bus3.busy, bus3.done}, bus3.overrun, exp);
            end
            step();
        end
    endtask

    task automatic test_inbuf_change();
        logic [4:0] exp;
        bus1.in_buf = 4'hF;
        bus1.start  = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int n = 0; n <= 11; n++) begin
            if (n == 1) bus1.in_buf = 4'h0;
            exp = model(n, 4'hF, 1);
            vectors++;
            if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done} !== exp) begin
                miscompares++;
                $display("[TB] FAIL inbuf_change n=%0d got=%b want=%b", n,
                         {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done}, exp);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        bus1.in_buf = 4'h3;
        bus1.start  = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int n = 0; n <= 21; n++) begin
            exp = (n < 10) ? model(n, 4'h3, 1) : model(n - 10, 4'hC, 1);
            vectors++;
            if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done} !== exp || bus1.overrun !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL back_to_back n=%0d got=%b/%b want=%b/0", n,
                         {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done}, bus1.overrun, exp);
            end
            if (n == 3) begin
                bus1.in_buf = 4'hC;
                bus1.start  = 1'b1;
            end else begin
                bus1.start  = 1'b0;
                if (n == 4) bus1.in_buf = 4'h0;
            end
            step();
        end
    endtask

    task automatic test_overrun();
        logic [4:0] exp;
        bus1.in_buf = 4'h1;
        bus1.start  = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int n = 0; n <= 21; n++) begin
            exp = (n < 10) ? model(n, 4'h1, 1) : model(n - 10, 4'h7, 1);
            vectors++;
            if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done} !== exp ||
                bus1.overrun !== (n == 5)) begin
                miscompares++;
                $display("[TB] FAIL overrun n=%0d got=%b/%b want=%b/%b", n,
                         {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done}, bus1.overrun,
                         exp, (n == 5));
            end
            bus1.start = 1'b0;
            if (n == 2) begin
                bus1.in_buf = 4'h2;
                bus1.start  = 1'b1;
            end else if (n == 4) begin
                bus1.in_buf = 4'h7;
                bus1.start  = 1'b1;
            end
            step();
        end
    endtask

    task automatic test_gap_start();
        logic [4:0] exp;
        bus1.in_buf = 4'h9;
        bus1.start  = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int n = 0; n <= 21; n++) begin
            exp = (n < 10) ? model(n, 4'h9, 1) : model(n - 10, 4'h5, 1);
            vectors++;
            if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done} !== exp || bus1.overrun !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL gap_start n=%0d got=%b/%b want=%b/0", n,
                         {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done}, bus1.overrun, exp);
            end
            bus1.start = (n == 9);
            if (n == 9) bus1.in_buf = 4'h5;
            step();
        end
    endtask

    task automatic test_mid_reset();
        logic [4:0] exp;
        bus1.in_buf = 4'hA;
        bus1.start  = 1'b1;
        step();
        bus1.start = 1'b0;
        for (int n = 0; n <= 5; n++) begin
            bus1.start = (n == 1);
            if (n == 1) bus1.in_buf = 4'hE;
            reset = (n == 3);
            if (n >= 4) begin
                vectors++;
                if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done, bus1.overrun} !== 6'b100000) begin
                    miscompares++;
                    $display("[TB] FAIL mid_reset n=%0d got=%b want=100000", n,
                             {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done, bus1.overrun});
                end
            end
            if (n == 5) begin
                bus1.in_buf = 4'h6;
                bus1.start  = 1'b1;
            end
            step();
        end
        bus1.start = 1'b0;
        for (int m = 0; m <= 12; m++) begin
            exp = model(m, 4'h6, 1);
            vectors++;
            if ({bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done} !== exp) begin
                miscompares++;
                $display("[TB] FAIL after_reset m=%0d got=%b want=%b", m,
                         {bus1.cs, bus1.sck, bus1.mosi, bus1.busy, bus1.done}, exp);
            end
            step();
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus1.in_buf = '0;
        bus1.start  = 1'b0;
        bus3.in_buf = '0;
        bus3.start  = 1'b0;
        #1;
        test_reset();
        test_single();
        step();
        test_div3();
        step();
        test_inbuf_change();
        step();
        test_back_to_back();
        step();
        test_overrun();
        step();
        test_gap_start();
        step();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
